mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with a sign-fixup cycle at the end.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [CW-1:0]    r_cnt;
    logic             r_is_div;
    logic             r_neg_res;
    logic             r_neg_rem;
    logic             r_dbz_pend;
    logic [WIDTH-1:0] r_a_raw;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_dbz;

    // Operand magnitudes taken at latch time; op[0] selects signed forms.
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;

    assign w_a_neg = op[0] & A[WIDTH-1];
    assign w_b_neg = op[0] & B[WIDTH-1];
    assign w_mag_a = w_a_neg ? (~A + 1'b1) : A;
    assign w_mag_b = w_b_neg ? (~B + 1'b1) : B;

    // Multiply step: conditionally add multiplicand to upper half, shift right.
    logic [WIDTH:0]   w_madd;
    assign w_madd = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);

    // Divide step: shift next dividend bit into the partial remainder and
    // keep the difference only when the divisor fits.
    logic [WIDTH:0]   w_shift;
    logic             w_fits;
    logic [WIDTH-1:0] w_rem_sub;
    assign w_shift   = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_fits    = (w_shift >= {1'b0, r_opnd});
    assign w_rem_sub = w_shift[WIDTH-1:0] - r_opnd;

    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = r_neg_res ? (~w_prod + 1'b1) : w_prod;
    assign w_quot_fix = r_neg_res ? (~r_acc_lo + 1'b1) : r_acc_lo;
    assign w_rem_fix  = r_neg_rem ? (~r_acc_hi + 1'b1) : r_acc_hi;

    always_comb begin
        // NOTE: default first so every path assigns w_next and no latch is inferred.
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = CALC;
            CALC:    if (r_cnt == CW'(WIDTH - 1)) w_next = FIX;
            FIX:     w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_dbz_pend <= 1'b0;
            r_a_raw    <= '0;
            r_opnd     <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_dbz      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cnt      <= '0;
                        r_is_div   <= op[1];
                        r_neg_res  <= w_a_neg ^ w_b_neg;
                        r_neg_rem  <= w_a_neg;
                        r_dbz_pend <= op[1] & (B == '0);
                        r_a_raw    <= A;
                        r_acc_hi   <= '0;
                        r_acc_lo   <= op[1] ? w_mag_a : w_mag_b;
                        r_opnd     <= op[1] ? w_mag_b : w_mag_a;
                    end
                end
                CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_is_div) begin
                        r_acc_hi <= w_fits ? w_rem_sub : w_shift[WIDTH-1:0];
                        r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_fits};
                    end else begin
                        r_acc_hi <= w_madd[WIDTH:1];
                        r_acc_lo <= {w_madd[0], r_acc_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    if (r_dbz_pend) begin
                        r_hi  <= r_a_raw;
                        r_lo  <= '1;
                        r_dbz <= 1'b1;
                    end else if (r_is_div) begin
                        r_hi  <= w_rem_fix;
                        r_lo  <= w_quot_fix;
                        r_dbz <= 1'b0;
                    end else begin
                        r_hi  <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo  <= w_prod_fix[WIDTH-1:0];
                        r_dbz <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != IDLE);
    assign done        = (r_state == DONE);
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz;

endmodule
